// File: rtl/serial_frame_tx.sv
// Purpose : parallel-to-serial frame transmitter (start 0, DATA_W bits LSB first, stop 1).
// Latency : start bit on the line at the accept edge; frame ends (DATA_W+2)*CLKS_PER_BIT cycles later.
// Backpres: tx_ready only in IDLE; tx_valid while busy is ignored, not queued.
//
// Ports:
//   clk       - clock, all state on rising edge
//   reset     - asynchronous, active-low reset
//   tx_data   - word to send, sampled only at the accept edge
//   tx_valid  - requester has a word on tx_data
//   tx_ready  - block can accept a word this cycle
//   tx_serial - serial line, idles high
//   tx_busy   - frame in progress
//   tx_done   - one-cycle pulse at frame completion
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TW-1:0] TMR_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]        state;
    logic [TW-1:0]     bit_tmr;
    logic [IW-1:0]     bit_idx;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic              bit_end;

    // The word is shifted right once per data bit, so the bit on the line is
    // always shift_q[0]; this keeps the output mux down to a single bit.
    assign shift_nxt = shift_q >> 1;
    assign bit_end   = (bit_tmr == TMR_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_tmr   <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            tx_serial <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            // Bit timer runs in every non-idle state and wraps at each bit boundary.
            if (state != ST_IDLE) begin
                bit_tmr <= bit_end ? '0 : bit_tmr + TW'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        shift_q   <= tx_data;
                        state     <= ST_START;
                        bit_tmr   <= '0;
                        tx_serial <= 1'b0;
                        tx_ready  <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state     <= ST_DATA;
                        bit_idx   <= '0;
                        tx_serial <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_LAST) begin
                            state     <= ST_STOP;
                            tx_serial <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + IW'(1);
                            shift_q   <= shift_nxt;
                            tx_serial <= shift_nxt[0];
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        state    <= ST_IDLE;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    tx_serial <= 1'b1;
                    tx_ready  <= 1'b1;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Purpose : bench for serial_frame_tx; two instances (8b/4clk and 5b/2clk) on one clock.
// Latency : n/a.
// Backpres: drivers hold tx_valid until tx_ready is seen, like a real requester.
module tb_serial_frame_tx;
    localparam int W0 = 8;
    localparam int C0 = 4;
    localparam int W1 = 5;
    localparam int C1 = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [W0-1:0] data0 = '0;
    logic          valid0 = 1'b0;
    logic          ready0, serial0, busy0, done0;
    logic [W1-1:0] data1 = '0;
    logic          valid1 = 1'b0;
    logic          ready1, serial1, busy1, done1;

    serial_frame_tx #(.DATA_W(W0), .CLKS_PER_BIT(C0)) dut0 (
        .clk(clk), .reset(reset), .tx_data(data0), .tx_valid(valid0),
        .tx_ready(ready0), .tx_serial(serial0), .tx_busy(busy0), .tx_done(done0)
    );
    serial_frame_tx #(.DATA_W(W1), .CLKS_PER_BIT(C1)) dut1 (
        .clk(clk), .reset(reset), .tx_data(data1), .tx_valid(valid1),
        .tx_ready(ready1), .tx_serial(serial1), .tx_busy(busy1), .tx_done(done1)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: words pushed at acceptance, popped when a frame appears.
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          st0[$];      // sample cycle at which each dut0 frame began
    logic        tracking[2];
    int          pos[2];
    logic [15:0] cur[2];

    initial begin
        tracking[0] = 1'b0; tracking[1] = 1'b0;
        pos[0] = 0; pos[1] = 0;
        cur[0] = '0; cur[1] = '0;
    end

    task automatic chk(input string name, input int d, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %b expected %b", name, d, cyc, act, exp);
        end
    endtask

    // Line value of frame bit k: 0 = start, 1..W = data LSB first, W+1 = stop.
    function automatic logic exp_bit(input logic [15:0] w, input int width, input int k);
        if (k == 0) return 1'b0;
        if (k <= width) return w[k-1];
        return 1'b1;
    endfunction

    task automatic mon(input int d, input logic s, input logic b, input logic r, input logic dn);
        int width;
        int cpb;
        width = (d == 0) ? W0 : W1;
        cpb   = (d == 0) ? C0 : C1;
        if (!reset) begin
            tracking[d] = 1'b0;
            chk("rst_serial", d, s, 1'b1);
            chk("rst_busy", d, b, 1'b0);
            chk("rst_ready", d, r, 1'b1);
            chk("rst_done", d, dn, 1'b0);
            return;
        end
        if (!tracking[d]) begin
            if (b) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_frame dut%0d cyc %0d: got frame expected none", d, cyc);
                    cur[d] = '0;
                end else begin
                    cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
                end
                tracking[d] = 1'b1;
                pos[d] = 0;
                if (d == 0) st0.push_back(cyc);
            end else begin
                chk("idle_serial", d, s, 1'b1);
                chk("idle_ready", d, r, 1'b1);
                chk("idle_done", d, dn, 1'b0);
                return;
            end
        end
        if (pos[d] < (width + 2) * cpb) begin
            chk("frame_serial", d, s, exp_bit(cur[d], width, pos[d] / cpb));
            chk("frame_busy", d, b, 1'b1);
            chk("frame_ready", d, r, 1'b0);
            chk("frame_done", d, dn, 1'b0);
            pos[d]++;
        end else begin
            chk("end_done", d, dn, 1'b1);
            chk("end_ready", d, r, 1'b1);
            chk("end_busy", d, b, 1'b0);
            chk("end_serial", d, s, 1'b1);
            tracking[d] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, serial0, busy0, ready0, done0);
        mon(1, serial1, busy1, ready1, done1);
    end

    task automatic send(input int d, input logic [15:0] w, input bit hold);
        int t;
        t = 0;
        @(negedge clk);
        if (d == 0) begin data0 = w[W0-1:0]; valid0 = 1'b1; end
        else        begin data1 = w[W1-1:0]; valid1 = 1'b1; end
        while (((d == 0) ? !ready0 : !ready1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if ((d == 0) ? !ready0 : !ready1) begin
            vectors++; errors++;
            $display("FAIL accept_timeout dut%0d: got ready=0 expected ready=1", d);
            if (d == 0) valid0 = 1'b0; else valid1 = 1'b0;
            return;
        end
        if (d == 0) q0.push_back({8'h00, w[W0-1:0]});
        else        q1.push_back({11'h000, w[W1-1:0]});
        @(posedge clk);
        #1;
        if (!hold) begin
            if (d == 0) valid0 = 1'b0; else valid1 = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((tracking[0] || tracking[1] || q0.size() != 0 || q1.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            vectors++; errors++;
            $display("FAIL drain_timeout: got frames pending expected none");
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        // Idle for 20 cycles: monitor checks line high, ready high, no done.
        repeat (20) @(negedge clk);

        // Single frame 0xA5.
        send(0, 16'h00A5, 1'b0);
        drain();

        // Back-to-back 0x00 then 0xFF with tx_valid held high.
        send(0, 16'h0000, 1'b1);
        send(0, 16'h00FF, 1'b0);
        drain();
        vectors++;
        if (st0.size() < 2 || st0[st0.size()-1] - st0[st0.size()-2] != (W0 + 2) * C0 + 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d expected %0d",
                     (st0.size() < 2) ? -1 : st0[st0.size()-1] - st0[st0.size()-2], (W0 + 2) * C0 + 1);
        end

        // Disturbance: tx_data toggles and tx_valid pulses while 0x3C is in flight.
        send(0, 16'h003C, 1'b0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            data0  = W0'($urandom);
            valid0 = (i % 3 == 1);
        end
        valid0 = 1'b0;
        drain();

        // Async reset in the 4th data bit, between clock edges.
        send(0, 16'h00C3, 1'b0);
        repeat (17) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_serial", 0, serial0, 1'b1);
        chk("async_busy", 0, busy0, 1'b0);
        chk("async_done", 0, done0, 1'b0);
        repeat (2) @(negedge clk);
        // Release with tx_valid already high: accept at the first edge out of reset.
        @(negedge clk);
        reset  = 1'b1;
        data0  = 8'h81;
        valid0 = 1'b1;
        q0.push_back(16'h0081);
        @(posedge clk);
        #1 valid0 = 1'b0;
        drain();

        // Narrow instance: 5'b10110 at 2 clocks per bit.
        send(1, 16'h0016, 1'b0);
        drain();

        // Randomised traffic on both instances concurrently.
        fork
            begin
                for (int i = 0; i < 8; i++) send(0, 16'($urandom), 1'($urandom_range(0, 1)));
            end
            begin
                for (int j = 0; j < 12; j++) send(1, 16'($urandom), 1'($urandom_range(0, 1)));
            end
        join
        @(negedge clk);
        valid0 = 1'b0;
        valid1 = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
